// File: rtl/ascon_block_feeder.sv
// Ascon-128a input feeder: pads AD/message blocks, adds the extra pad block after a
// full last block, and hands blocks to the core over a valid/ready handshake.
module ascon_block_feeder #(
    parameter int unsigned pBLOCK_BITS = 128,
    parameter int unsigned pCNT_BITS   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go_i,
    input  logic                   ctrl_wr_i,
    input  logic [4:0]             ctrl_i,
    input  logic [pBLOCK_BITS-1:0] ad_block_i,
    input  logic [pBLOCK_BITS-1:0] msg_block_i,
    input  logic [pCNT_BITS-1:0]   ad_bytes_i,
    input  logic [pCNT_BITS-1:0]   msg_bytes_i,
    input  logic                   core_ready_i,
    output logic [pBLOCK_BITS-1:0] core_data_o,
    output logic                   core_valid_o,
    output logic                   core_last_o,
    output logic                   core_eot_o,
    output logic                   core_select_o,
    output logic                   core_key_valid_o,
    output logic                   busy_o,
    output logic                   consumed_o,
    output logic                   err_o
);

    localparam int unsigned NBYTES = pBLOCK_BITS / 8;
    localparam logic [pBLOCK_BITS-1:0] PAD_BLK = {8'h80, {(pBLOCK_BITS-8){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PRESENT, S_PAD} state_e;

    state_e                 state_q, state_d;
    logic [pBLOCK_BITS-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   eot_q, eot_d;
    logic                   sel_q, sel_d;
    logic                   key_q, key_d;
    logic                   busy_q, busy_d;
    logic                   consumed_q, consumed_d;
    logic                   err_q, err_d;
    logic                   need_pad_q, need_pad_d;

    logic                   wr_valid_c, wr_last_c, wr_eot_c, wr_key_c, wr_sel_c;
    logic [pCNT_BITS-1:0]   n_raw_c, n_c;
    logic                   over_c, full_c, short_c, empty_ad_c;
    logic [pBLOCK_BITS-1:0] blk_c, padded_c;
    logic                   hs_c;

    assign wr_valid_c = ctrl_i[0];
    assign wr_last_c  = ctrl_i[1];
    assign wr_eot_c   = ctrl_i[2];
    assign wr_key_c   = ctrl_i[3];
    assign wr_sel_c   = ctrl_i[4];

    assign blk_c      = wr_sel_c ? msg_block_i : ad_block_i;
    assign n_raw_c    = wr_sel_c ? msg_bytes_i : ad_bytes_i;
    assign over_c     = n_raw_c > pCNT_BITS'(NBYTES);
    assign n_c        = over_c ? pCNT_BITS'(NBYTES) : n_raw_c;
    assign full_c     = n_c == pCNT_BITS'(NBYTES);
    assign short_c    = !full_c;
    assign empty_ad_c = !wr_sel_c && wr_last_c && (n_c == '0);
    assign hs_c       = valid_q && core_ready_i;

    // Copy the first n bytes; the 10* pad byte goes at position n only on a last block.
    always_comb begin
        padded_c = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (pCNT_BITS'(i) < n_c) begin
                padded_c[pBLOCK_BITS-1-8*i -: 8] = blk_c[pBLOCK_BITS-1-8*i -: 8];
            end else if ((pCNT_BITS'(i) == n_c) && wr_last_c) begin
                padded_c[pBLOCK_BITS-1-8*i -: 8] = 8'h80;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        eot_d      = eot_q;
        sel_d      = sel_q;
        key_d      = key_q;
        busy_d     = busy_q;
        consumed_d = consumed_q;
        err_d      = err_q;
        need_pad_d = need_pad_q;

        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_ARMED;
                end else if (ctrl_wr_i) begin
                    key_d = wr_key_c;
                end
            end
            S_ARMED: begin
                if (ctrl_wr_i) begin
                    key_d = wr_key_c;
                    if (wr_valid_c) begin
                        if (over_c || (short_c && !wr_last_c)) begin
                            err_d = 1'b1;
                        end
                        if (empty_ad_c) begin
                            // Nothing to send; just report the AD as consumed.
                            consumed_d = 1'b1;
                            if (wr_eot_c) begin
                                busy_d  = 1'b0;
                                state_d = S_IDLE;
                            end
                        end else begin
                            data_d     = padded_c;
                            need_pad_d = full_c && wr_last_c;
                            last_d     = wr_last_c && !full_c;
                            eot_d      = wr_eot_c;
                            sel_d      = wr_sel_c;
                            consumed_d = 1'b0;
                            valid_d    = 1'b1;
                            state_d    = S_PRESENT;
                        end
                    end
                end
            end
            S_PRESENT: begin
                if (ctrl_wr_i) begin
                    err_d = 1'b1;
                end
                if (hs_c) begin
                    consumed_d = 1'b1;
                    if (need_pad_q) begin
                        data_d     = PAD_BLK;
                        last_d     = 1'b1;
                        need_pad_d = 1'b0;
                        state_d    = S_PAD;
                    end else begin
                        valid_d = 1'b0;
                        if (eot_q) begin
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_ARMED;
                        end
                    end
                end
            end
            S_PAD: begin
                if (ctrl_wr_i) begin
                    err_d = 1'b1;
                end
                if (hs_c) begin
                    consumed_d = 1'b1;
                    valid_d    = 1'b0;
                    if (eot_q) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            eot_q      <= 1'b0;
            sel_q      <= 1'b0;
            key_q      <= 1'b0;
            busy_q     <= 1'b0;
            consumed_q <= 1'b0;
            err_q      <= 1'b0;
            need_pad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            eot_q      <= eot_d;
            sel_q      <= sel_d;
            key_q      <= key_d;
            busy_q     <= busy_d;
            consumed_q <= consumed_d;
            err_q      <= err_d;
            need_pad_q <= need_pad_d;
        end
    end

    assign core_data_o      = data_q;
    assign core_valid_o     = valid_q;
    assign core_last_o      = last_q;
    assign core_eot_o       = eot_q;
    assign core_select_o    = sel_q;
    assign core_key_valid_o = key_q;
    assign busy_o           = busy_q;
    assign consumed_o       = consumed_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_ascon_block_feeder.sv
// Bench for ascon_block_feeder: directed scenarios plus randomized transfers checked
// against a block-list model built from the padding rules.
module tb_ascon_block_feeder;

    typedef struct packed {
        logic [127:0] d;
        logic         last;
        logic         eot;
        logic         sel;
    } blk_t;

    localparam logic [127:0] PAD = {8'h80, 120'h0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         go_i, ctrl_wr_i, core_ready_i;
    logic [4:0]   ctrl_i, ad_bytes_i, msg_bytes_i;
    logic [127:0] ad_block_i, msg_block_i, core_data_o;
    logic         core_valid_o, core_last_o, core_eot_o, core_select_o;
    logic         core_key_valid_o, busy_o, consumed_o, err_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    blk_t obs_q[$];
    blk_t exp_q[$];
    logic exp_err, exp_key, exp_eot;

    always #5 clk = ~clk;

    ascon_block_feeder dut (
        .clk(clk), .rst_n(rst_n), .go_i(go_i), .ctrl_wr_i(ctrl_wr_i), .ctrl_i(ctrl_i),
        .ad_block_i(ad_block_i), .msg_block_i(msg_block_i), .ad_bytes_i(ad_bytes_i),
        .msg_bytes_i(msg_bytes_i), .core_ready_i(core_ready_i), .core_data_o(core_data_o),
        .core_valid_o(core_valid_o), .core_last_o(core_last_o), .core_eot_o(core_eot_o),
        .core_select_o(core_select_o), .core_key_valid_o(core_key_valid_o),
        .busy_o(busy_o), .consumed_o(consumed_o), .err_o(err_o)
    );

    // Record every block the core accepts.
    always @(posedge clk) begin
        if (rst_n && core_valid_o && core_ready_i)
            obs_q.push_back({core_data_o, core_last_o, core_eot_o, core_select_o});
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected block list for one control write, from the padding rules.
    task automatic model(input logic sel, input logic last, input logic eot,
                         input logic [127:0] blk, input int cnt);
        int           n;
        logic [127:0] d;
        blk_t         b;
        n = (cnt > 16) ? 16 : cnt;
        if (cnt > 16 || (!last && n < 16)) exp_err = 1'b1;
        if (!sel && n == 0 && last) return;
        d = blk & ~((128'd1 << (128 - 8*n)) - 128'd1);
        if (last && n < 16) d = d | (128'h80 << (8*(15 - n)));
        b.d = d; b.last = last && (n != 16); b.eot = eot; b.sel = sel;
        exp_q.push_back(b);
        if (n == 16 && last) begin
            b.d = PAD; b.last = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic do_go();
        @(negedge clk); go_i = 1'b1;
        @(negedge clk); go_i = 1'b0;
        exp_err = 1'b0;
        chk("busy_after_go", 128'(busy_o), 128'd1);
    endtask

    task automatic start_txn(input logic sel, input logic last, input logic eot,
                             input logic key, input logic [127:0] ad, input logic [127:0] msg,
                             input logic [4:0] adb, input logic [4:0] msgb);
        exp_q.delete(); obs_q.delete();
        exp_key = key; exp_eot = eot;
        model(sel, last, eot, sel ? msg : ad, sel ? int'(msgb) : int'(adb));
        @(negedge clk);
        ctrl_wr_i = 1'b1; ctrl_i = {sel, key, eot, last, 1'b1};
        ad_block_i = ad; msg_block_i = msg; ad_bytes_i = adb; msg_bytes_i = msgb;
        @(negedge clk);
        ctrl_wr_i = 1'b0;
        if (exp_q.size() != 0) chk("consumed_cleared", 128'(consumed_o), 128'd0);
    endtask

    task automatic finish_txn(input bit rand_rdy);
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (!core_valid_o && obs_q.size() >= exp_q.size()) done = 1'b1;
            else begin
                core_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
            end
        end
        core_ready_i = 1'b0;
        if (!done) chk("handshake_timeout", 128'd1, 128'd0);
        chk("n_blocks", 128'(obs_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk("blk_data", obs_q[i].d, exp_q[i].d);
            chk("blk_flags", 128'({obs_q[i].last, obs_q[i].eot, obs_q[i].sel}),
                128'({exp_q[i].last, exp_q[i].eot, exp_q[i].sel}));
        end
        chk("consumed", 128'(consumed_o), 128'd1);
        chk("err", 128'(err_o), 128'(exp_err));
        chk("busy", 128'(busy_o), 128'(!exp_eot));
        chk("key_valid", 128'(core_key_valid_o), 128'(exp_key));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] held;
        logic [4:0]   nb;
        logic         sel, last, key;
        int           k;

        rst_n = 1'b0; go_i = 1'b0; ctrl_wr_i = 1'b0; ctrl_i = '0; core_ready_i = 1'b0;
        ad_block_i = '0; msg_block_i = '0; ad_bytes_i = '0; msg_bytes_i = '0; exp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({core_valid_o, core_last_o, core_eot_o, core_select_o,
            core_key_valid_o, busy_o, consumed_o, err_o}), 128'd0);
        chk("reset_data", core_data_o, 128'd0);
        rst_n = 1'b1;

        // Full AD block then full message block.
        do_go();
        start_txn(1'b0, 1'b1, 1'b0, 1'b1, 128'h12345678abcdef0187654321deadbeef, rnd128(), 5'd16, 5'd16);
        finish_txn(1'b0);
        if (obs_q.size() == 2) begin
            chk("t1_ad_blk", obs_q[0].d, 128'h12345678abcdef0187654321deadbeef);
            chk("t1_ad_last", 128'(obs_q[0].last), 128'd0);
            chk("t1_pad_blk", obs_q[1].d, PAD);
        end
        start_txn(1'b1, 1'b1, 1'b1, 1'b1, rnd128(), rnd128(), 5'd0, 5'd16);
        finish_txn(1'b0);

        // Partial message.
        do_go();
        start_txn(1'b1, 1'b1, 1'b1, 1'b0, rnd128(), 128'hf1023000abcd_1122334455667788_9900, 5'd0, 5'd5);
        finish_txn(1'b1);
        if (obs_q.size() == 1) chk("t2_partial", obs_q[0].d, 128'hf1023000ab80_0000000000000000_0000);

        // Backpressure for 7 cycles.
        do_go();
        start_txn(1'b0, 1'b1, 1'b0, 1'b1, rnd128(), rnd128(), 5'd7, 5'd0);
        held = core_data_o;
        for (int c = 0; c < 7; c++) begin
            chk("bp_valid", 128'(core_valid_o), 128'd1);
            chk("bp_data", core_data_o, held);
            @(negedge clk);
        end
        finish_txn(1'b0);

        // Overrun while presenting.
        start_txn(1'b1, 1'b1, 1'b1, 1'b1, rnd128(), rnd128(), 5'd0, 5'd3);
        held = core_data_o;
        ctrl_wr_i = 1'b1; ctrl_i = 5'h1F; msg_block_i = rnd128(); msg_bytes_i = 5'd9;
        @(negedge clk); ctrl_wr_i = 1'b0;
        exp_err = 1'b1;
        chk("ovr_err", 128'(err_o), 128'd1);
        chk("ovr_data", core_data_o, held);
        chk("ovr_valid", 128'(core_valid_o), 128'd1);
        finish_txn(1'b0);
        do_go();
        chk("err_cleared", 128'(err_o), 128'd0);

        // Empty AD returns to ARMED, then a message closes the transfer.
        start_txn(1'b0, 1'b1, 1'b0, 1'b0, rnd128(), rnd128(), 5'd0, 5'd0);
        finish_txn(1'b0);
        start_txn(1'b1, 1'b1, 1'b1, 1'b0, rnd128(), rnd128(), 5'd0, 5'd11);
        finish_txn(1'b1);

        // go and control write together in IDLE: write is dropped.
        @(negedge clk);
        go_i = 1'b1; ctrl_wr_i = 1'b1; ctrl_i = 5'h0B; ad_bytes_i = 5'd4;
        @(negedge clk); go_i = 1'b0; ctrl_wr_i = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        chk("gowr_busy", 128'(busy_o), 128'd1);
        chk("gowr_valid", 128'(core_valid_o), 128'd0);
        chk("gowr_key", 128'(core_key_valid_o), 128'd0);
        start_txn(1'b1, 1'b1, 1'b1, 1'b0, rnd128(), rnd128(), 5'd0, 5'd2);
        finish_txn(1'b0);

        // Reset during the pad block.
        do_go();
        start_txn(1'b0, 1'b1, 1'b1, 1'b1, rnd128(), rnd128(), 5'd16, 5'd0);
        core_ready_i = 1'b1;
        @(negedge clk); core_ready_i = 1'b0;
        chk("pad_presented", core_data_o, PAD);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_flags", 128'({core_valid_o, core_last_o, core_eot_o, core_select_o,
            core_key_valid_o, busy_o, consumed_o, err_o}), 128'd0);
        chk("rst_async_data", core_data_o, 128'd0);
        @(negedge clk); rst_n = 1'b1;
        do_go();
        start_txn(1'b1, 1'b1, 1'b1, 1'b0, rnd128(), rnd128(), 5'd0, 5'd16);
        finish_txn(1'b1);

        // Randomized transfers.
        for (int s = 0; s < 25; s++) begin
            do_go();
            k = $urandom_range(1, 4);
            for (int t = 0; t < k; t++) begin
                sel  = 1'($urandom_range(0, 1));
                last = ($urandom_range(0, 3) != 0);
                key  = 1'($urandom_range(0, 1));
                nb   = ($urandom_range(0, 2) == 0) ? 5'd16 : 5'($urandom_range(0, 20));
                start_txn(sel, last, (t == k - 1), key, rnd128(), rnd128(), nb, nb);
                finish_txn(1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_block_feeder.md
Name: ascon_block_feeder

Overview:
- Upstream stage of the Ascon-128a core inside the CW305 register wrapper.
- Takes 128-bit AD and message blocks, valid-byte counts and control writes from the register file.
- Applies Ascon 10* padding, inserts the extra pad block a full last block requires, and presents blocks to the core on a valid/ready handshake.
- Drives the busy and read_data_core status bits polled over USB.

Parameters:
- pBLOCK_BITS, 128, rate block width in bits; fixed at 128 for Ascon-128a.
- pCNT_BITS, 5, width of the valid-byte count inputs (0..16).

Ports:
- clk  in  1  crypto clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- go_i  in  1  one-cycle start pulse (REG_CRYPT_GO bit 0, already synchronised).
- ctrl_wr_i  in  1  one-cycle pulse: REG_CONTROL written.
- ctrl_i  in  5  [0] valid, [1] last, [2] eot, [3] key_valid, [4] select (1 = message, 0 = AD).
- ad_block_i  in  128  AD block, byte 0 at [127:120].
- msg_block_i  in  128  message block, byte 0 at [127:120].
- ad_bytes_i  in  5  valid AD bytes, 0..16.
- msg_bytes_i  in  5  valid message bytes, 0..16.
- core_ready_i  in  1  core accepts the block this cycle.
- core_data_o  out  128  padded block to core.
- core_valid_o  out  1  block valid.
- core_last_o  out  1  last block of the current AD or message segment.
- core_eot_o  out  1  end of transfer.
- core_select_o  out  1  0 = AD, 1 = message.
- core_key_valid_o  out  1  latched ctrl_i[3].
- busy_o  out  1  status bit 0.
- consumed_o  out  1  status bit 1 (read_data_core), sticky.
- err_o  out  1  sticky error.

Behaviour:
- Reset: every output is 0; state is IDLE.
- IDLE:
  - On go_i, set busy_o=1 and move to ARMED.
  - ctrl_wr_i here only updates core_key_valid_o.
- ARMED:
  - On ctrl_wr_i with ctrl_i[0]=1, select the block and count via ctrl_i[4].
  - Latch the padded block plus last, eot and select; clear consumed_o; move to PRESENT.
  - core_valid_o rises on the next cycle (1-cycle latency).
  - ctrl_wr_i with ctrl_i[0]=0 updates key_valid only and stays in ARMED.
- Padding, with n = the selected byte count:
  - n<16: bytes 0..n-1 are copied, byte n is 0x80, bytes n+1..15 are 0x00. The pad is applied only when last=1; with last=0 and n<16, set err_o and still send the block unpadded.
  - n=16: the block is copied unchanged, and need_pad = last.
  - n>16: clamp to 16 and set err_o.
  - AD with n=0 and last=1: no block is sent. consumed_o is set next cycle; next state is IDLE if eot, otherwise ARMED.
  - Message with n=0 and last=1: send a single pad block 0x80 followed by 0x00s.
- PRESENT:
  - core_valid_o=1; data and flags stay stable until core_ready_i.
  - On the handshake (valid & ready): consumed_o<=1.
  - If need_pad, go to PAD with core_last_o forced to 0 for the current block.
  - Otherwise, if eot, go to IDLE with busy_o<=0; else go to ARMED.
- PAD:
  - Present 128'h80 followed by 15 zero bytes, with last=1, the same select and the latched eot.
  - On the handshake: IDLE (busy_o<=0) if eot, else ARMED. consumed_o is already 1.
- Simultaneous and unexpected events:
  - ctrl_wr_i in PRESENT or PAD is ignored and sets err_o (overrun).
  - go_i while busy_o=1 is ignored.
  - go_i and ctrl_wr_i in the same cycle in IDLE: go wins and the control write is dropped.
- err_o clears only on reset or on go_i accepted in IDLE.
- Reset asserted mid-transfer drops the block immediately; core_valid_o goes to 0 asynchronously.

Test Plan:
1. AD and message, 16 bytes each, full blocks:
   - Stimulus: go; ctrl 0x0B with ad_bytes=16, AD 0x12345678abcdef0187654321deadbeef; ready=1.
   - Response: AD block unchanged with last=0, then pad block 0x80 followed by 0s with last=1, then consumed_o=1.
   - Stimulus: ctrl 0x1F with msg_bytes=16.
   - Response: message block unchanged, then message pad block with eot=1; busy_o falls one cycle after that handshake.
2. Partial message:
   - Stimulus: msg_bytes=5, msg 0xf1023000abcd..., last=1, eot=1.
   - Response: core_data_o=0xf1023000ab80 followed by 0s; no pad block; busy_o=0.
3. Backpressure:
   - Stimulus: hold core_ready_i=0 for 7 cycles.
   - Response: core_valid_o=1 and data stable for all 7 cycles; exactly one handshake is counted.
4. Overrun:
   - Stimulus: ctrl_wr_i while in PRESENT.
   - Response: err_o=1 and the presented block is unchanged.
   - Stimulus: next go_i in IDLE.
   - Response: err_o=0.
5. Empty AD:
   - Stimulus: select=0, ad_bytes=0, last=1.
   - Response: no core_valid_o pulse; consumed_o=1 one cycle later; state returns to ARMED.
6. Reset:
   - Stimulus: rst_n low mid-PAD.
   - Response: all outputs 0 immediately.
   - Stimulus: release reset, then go_i.
   - Response: busy_o=1 next cycle.
